// File: rtl/flag_unit.sv
// Carry/zero flag unit: one-entry pending M-stage update, committed at the end of M.
// Build option FLAG_FWD_EN forwards the pending update to EX; otherwise EX is stalled on a hazard.
module flag_unit #(
  parameter logic RESET_C = 1'b0,
  parameter logic RESET_Z = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       flush,
  input  logic       ex_valid,
  input  logic [3:0] ex_opcode,
  input  logic [1:0] ex_funct,
  input  logic       ex_wb_en,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       mem_load_zero,
  output logic       C_flag,
  output logic       Z_flag,
  output logic       arch_c,
  output logic       arch_z,
  output logic       flag_stall
);

  logic upd;
  logic dec_c_we, dec_z_we, dec_lw;
  logic m_c_we, m_z_we, m_lw, m_c, m_z;
  logic m_z_val;

  assign upd = ex_valid & ex_wb_en & ~flush;

  always_comb begin
    dec_c_we = 1'b0;
    dec_z_we = 1'b0;
    dec_lw   = 1'b0;
    case (ex_opcode)
      4'b0000, 4'b0001: begin
        dec_c_we = upd;
        dec_z_we = upd;
      end
      4'b0010: dec_z_we = upd;
      4'b0100: begin
        dec_z_we = upd;
        dec_lw   = 1'b1;
      end
      default: ;
    endcase
  end

  // A load's Z comes from the data returning in M, not from the ALU.
  assign m_z_val = m_lw ? mem_load_zero : m_z;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_c_we <= 1'b0;
      m_z_we <= 1'b0;
      m_lw   <= 1'b0;
      m_c    <= 1'b0;
      m_z    <= 1'b0;
    end else if (flush) begin
      m_c_we <= 1'b0;
      m_z_we <= 1'b0;
      m_lw   <= 1'b0;
    end else if (!stall) begin
      m_c_we <= dec_c_we;
      m_z_we <= dec_z_we;
      m_lw   <= dec_lw;
      m_c    <= alu_carry;
      m_z    <= alu_zero;
    end
  end

  // Flush drains the older M entry even while the pipe is otherwise frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      arch_c <= RESET_C;
      arch_z <= RESET_Z;
    end else if (!stall || flush) begin
      if (m_c_we) arch_c <= m_c;
      if (m_z_we) arch_z <= m_z_val;
    end
  end

`ifdef FLAG_FWD_EN
  logic unused_funct;
  assign unused_funct = ^ex_funct;
  assign C_flag     = m_c_we ? m_c : arch_c;
  assign Z_flag     = m_z_we ? m_z_val : arch_z;
  assign flag_stall = 1'b0;
`else
  logic ex_cond;
  assign ex_cond    = ex_valid & ((ex_opcode == 4'b0000) | (ex_opcode == 4'b0010));
  assign C_flag     = arch_c;
  assign Z_flag     = arch_z;
  assign flag_stall = ex_cond & (((ex_funct == 2'b10) & m_c_we) |
                                 ((ex_funct == 2'b01) & m_z_we));
`endif

endmodule

// File: tb/tb_flag_unit.sv
// Bench for flag_unit: directed scenarios with literal expectations, then random
// traffic checked every cycle against a pending-update reference model.
module tb_flag_unit;

  localparam logic RC = 1'b1;
  localparam logic RZ = 1'b0;

  logic clk = 1'b0;
  logic rst, stall, flush, ex_valid, ex_wb_en, alu_carry, alu_zero, mem_load_zero;
  logic [3:0] ex_opcode;
  logic [1:0] ex_funct;
  logic C_flag, Z_flag, arch_c, arch_z, flag_stall;

  int n_tests = 0;
  int n_fail  = 0;

  flag_unit #(.RESET_C(RC), .RESET_Z(RZ)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_wb_en(ex_wb_en), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .mem_load_zero(mem_load_zero),
    .C_flag(C_flag), .Z_flag(Z_flag), .arch_c(arch_c), .arch_z(arch_z),
    .flag_stall(flag_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { bit cw; bit zw; bit lw; bit c; bit z; } upd_t;
  upd_t pend[$];
  bit   mod_c, mod_z;
  bit   model_ok = 1'b0;

  function automatic bit writes_c(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1);
  endfunction
  function automatic bit writes_z(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd4);
  endfunction

  always @(negedge clk) begin
    bit pc, pz, pz_val, e_c, e_z, e_st, tests_c, tests_z;
    upd_t u;
    if (model_ok) begin
      pc = 0; pz = 0; pz_val = 0;
      if (pend.size() != 0) begin
        pc = pend[0].cw;
        pz = pend[0].zw;
        pz_val = pend[0].lw ? mem_load_zero : pend[0].z;
      end
`ifdef FLAG_FWD_EN
      e_c  = pc ? pend[0].c : mod_c;
      e_z  = pz ? pz_val : mod_z;
      e_st = 0;
`else
      e_c = mod_c;
      e_z = mod_z;
      tests_c = ex_valid && (ex_opcode == 4'd0 || ex_opcode == 4'd2) && ex_funct == 2'b10;
      tests_z = ex_valid && (ex_opcode == 4'd0 || ex_opcode == 4'd2) && ex_funct == 2'b01;
      e_st = (tests_c && pc) || (tests_z && pz);
`endif
      chk("C_flag", C_flag, e_c);
      chk("Z_flag", Z_flag, e_z);
      chk("arch_c", arch_c, mod_c);
      chk("arch_z", arch_z, mod_z);
      chk("flag_stall", flag_stall, e_st);
    end
    if (rst === 1'b1) begin
      mod_c = RC;
      mod_z = RZ;
      pend.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (!stall || flush) begin
        if (pend.size() != 0) begin
          if (pend[0].cw) mod_c = pend[0].c;
          if (pend[0].zw) mod_z = pend[0].lw ? mem_load_zero : pend[0].z;
        end
        pend.delete();
        if (!flush && ex_valid && ex_wb_en &&
            (writes_c(ex_opcode) || writes_z(ex_opcode))) begin
          u.cw = writes_c(ex_opcode);
          u.zw = writes_z(ex_opcode);
          u.lw = (ex_opcode == 4'd4);
          u.c  = alu_carry;
          u.z  = alu_zero;
          pend.push_back(u);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit v, input logic [3:0] op, input logic [1:0] f,
                      input bit wb, input bit c, input bit z, input bit mlz,
                      input bit st, input bit fl);
    @(posedge clk);
    #1;
    rst = 0; ex_valid = v; ex_opcode = op; ex_funct = f; ex_wb_en = wb;
    alu_carry = c; alu_zero = z; mem_load_zero = mlz; stall = st; flush = fl;
    #3;
  endtask

  task automatic idle();
    step(0, 4'd15, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [3:0] ops [4];
    ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd4;
    rst = 1; stall = 0; flush = 0; ex_valid = 0; ex_opcode = 0; ex_funct = 0;
    ex_wb_en = 0; alu_carry = 0; alu_zero = 0; mem_load_zero = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    #3;
    chk("rst arch_c", arch_c, 1'b1);
    chk("rst arch_z", arch_z, 1'b0);
    chk("rst C_flag", C_flag, 1'b1);
    chk("rst Z_flag", Z_flag, 1'b0);
    chk("rst flag_stall", flag_stall, 1'b0);

    // forwarding of the newest pending carry to an ADC
    step(1, 4'd0, 2'b00, 1, 0, 1, 0, 0, 0);
    chk("add1 C_flag", C_flag, 1'b1);
    step(1, 4'd0, 2'b00, 1, 1, 0, 0, 0, 0);
`ifdef FLAG_FWD_EN
    chk("add2 C_flag fwd", C_flag, 1'b0);
    chk("add2 Z_flag fwd", Z_flag, 1'b1);
`else
    chk("add2 C_flag", C_flag, 1'b1);
`endif
    step(1, 4'd0, 2'b10, 1, 0, 0, 0, 0, 0);
    chk("adc arch_c", arch_c, 1'b0);
`ifdef FLAG_FWD_EN
    chk("adc C_flag fwd", C_flag, 1'b1);
`else
    chk("adc flag_stall", flag_stall, 1'b1);
    chk("adc C_flag", C_flag, 1'b0);
`endif
    idle();
    chk("adc+1 arch_c", arch_c, 1'b1);
    chk("adc+1 arch_z", arch_z, 1'b0);

    // cancelled ADC leaves flags alone
    step(1, 4'd0, 2'b00, 1, 0, 1, 0, 0, 0);
    idle();
    step(1, 4'd0, 2'b10, 0, 1, 0, 0, 0, 0);
    chk("cancel pre arch_c", arch_c, 1'b0);
    chk("cancel pre arch_z", arch_z, 1'b1);
    idle();
    chk("cancel arch_c", arch_c, 1'b0);
    chk("cancel arch_z", arch_z, 1'b1);
    chk("cancel flag_stall", flag_stall, 1'b0);

    // LW zero forwarded to NDZ
    step(1, 4'd0, 2'b00, 1, 0, 0, 0, 0, 0);
    step(1, 4'd4, 2'b00, 1, 1, 0, 0, 0, 0);
    step(1, 4'd2, 2'b01, 0, 0, 0, 1, 0, 0);
    chk("lw arch_z", arch_z, 1'b0);
`ifdef FLAG_FWD_EN
    chk("lw Z_flag fwd", Z_flag, 1'b1);
`else
    chk("lw flag_stall", flag_stall, 1'b1);
    chk("lw Z_flag", Z_flag, 1'b0);
`endif
    idle();
    chk("lw+1 arch_z", arch_z, 1'b1);

    // flush over stall: bubble into M, older entry still commits
    step(1, 4'd0, 2'b00, 1, 1, 0, 0, 0, 0);
    step(1, 4'd0, 2'b00, 1, 0, 1, 0, 1, 1);
    chk("flush pre arch_c", arch_c, 1'b0);
    idle();
    chk("flush arch_c", arch_c, 1'b1);
    chk("flush arch_z", arch_z, 1'b0);
    chk("flush C_flag", C_flag, 1'b1);
    idle();
    chk("flush+2 arch_c", arch_c, 1'b1);

    // stall holds M and suppresses commit
    step(1, 4'd0, 2'b00, 1, 0, 1, 0, 0, 0);
    step(1, 4'd0, 2'b00, 1, 1, 0, 0, 1, 0);
    idle();
    chk("stall hold arch_c", arch_c, 1'b1);
    chk("stall hold arch_z", arch_z, 1'b0);
    idle();
    chk("stall rel arch_c", arch_c, 1'b0);
    chk("stall rel arch_z", arch_z, 1'b1);

    // ADD then ADZ: hazard one cycle without forwarding
    step(1, 4'd0, 2'b00, 1, 1, 0, 0, 0, 0);
    step(1, 4'd0, 2'b01, 0, 0, 0, 0, 0, 0);
`ifdef FLAG_FWD_EN
    chk("adz flag_stall", flag_stall, 1'b0);
    chk("adz Z_flag fwd", Z_flag, 1'b0);
`else
    chk("adz flag_stall", flag_stall, 1'b1);
    chk("adz Z_flag", Z_flag, 1'b1);
`endif
    step(1, 4'd0, 2'b01, 1, 0, 0, 0, 0, 0);
    chk("adz2 flag_stall", flag_stall, 1'b0);
    chk("adz2 Z_flag", Z_flag, 1'b0);

    // reset mid-operation discards pending update
    step(1, 4'd0, 2'b00, 1, 0, 1, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1; ex_valid = 0;
    @(posedge clk);
    #1 rst = 0;
    #3;
    chk("midrst arch_c", arch_c, 1'b1);
    chk("midrst arch_z", arch_z, 1'b0);
    idle();
    chk("midrst+1 arch_z", arch_z, 1'b0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      rst           = ($urandom_range(0, 99) == 0);
      stall         = ($urandom_range(0, 5) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      ex_valid      = ($urandom_range(0, 5) != 0);
      ex_opcode     = ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 3)]
                                                   : 4'($urandom_range(0, 15));
      ex_funct      = 2'($urandom_range(0, 3));
      ex_wb_en      = ($urandom_range(0, 4) != 0);
      alu_carry     = 1'($urandom);
      alu_zero      = 1'($urandom);
      mem_load_zero = 1'($urandom);
    end
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
